// File: rtl/booth_iter_mult.sv
// booth_iter_mult
// Iterative radix-4 Booth multiplier. It retires one partial product per
// clock, so a WIDTH x WIDTH product takes N_PP = WIDTH/2+1 cycles after the
// operands are accepted. Each operand can be signed or unsigned on its own.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous abort of any in-flight or held operation
//   in_valid     operand request
//   in_ready     block is idle and can accept operands
//   in_a, in_b   multiplicand and multiplier (WIDTH bits each)
//   in_a_signed  in_a is two's complement when 1
//   in_b_signed  in_b is two's complement when 1
//   out_valid    product available (held until out_ready)
//   out_ready    consumer accepts the product
//   out_prod     full 2*WIDTH-bit product; reads as zero unless out_valid
module booth_iter_mult #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_a_signed,
   input  logic               in_b_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod
);

   localparam int N_PP = WIDTH / 2 + 1;
   localparam int PW   = 2 * WIDTH;
   localparam int CW   = $clog2(N_PP + 1);
   localparam logic [CW-1:0] LAST_DIGIT = CW'(N_PP - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // The multiplicand moves left by two bits every cycle, so the current
   // partial product is always aligned with the accumulator. The multiplier
   // moves right by two bits, so the current Booth window is always in bits
   // [2:0]. Bit 0 of the loaded multiplier is the implicit b[-1] = 0.
   logic [PW-1:0]    mcand;
   logic [WIDTH+2:0] mplier;
   logic             last_plus;
   logic [CW-1:0]    count;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    pp;
   logic             accept;

   assign accept = (state == IDLE) && in_valid && !flush;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and handshake outputs. Flush wins over both handshakes.
   // The product is masked to zero outside DONE, so stale accumulator
   // contents are never visible.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_prod   = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = BUSY;
         end
         BUSY: begin
            if (count == LAST_DIGIT) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            out_prod  = acc;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Booth recoding of the current window into a partial product. The top
   // digit can only be 0 or +1, because the multiplier is extended by two
   // bits. It is taken from the flag captured at acceptance, so no negation
   // or doubling is ever applied to it.
   always_comb begin
      pp = '0;
      if (count == LAST_DIGIT) begin
         pp = last_plus ? mcand : '0;
      end else begin
         case (mplier[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
         endcase
      end
   end

   // Datapath. Operands are captured once on acceptance and are never
   // sampled again. Flush only resets the digit counter, because the
   // output mask already hides the discarded accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand     <= '0;
         mplier    <= '0;
         last_plus <= 1'b0;
         count     <= '0;
         acc       <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (accept) begin
         mcand     <= {{WIDTH{in_a_signed & in_a[WIDTH-1]}}, in_a};
         mplier    <= {{2{in_b_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
         last_plus <= !in_b_signed && in_b[WIDTH-1];
         count     <= '0;
         acc       <= '0;
      end else if (state == BUSY) begin
         acc    <= acc + pp;
         mcand  <= mcand << 2;
         mplier <= mplier >> 2;
         count  <= count + 1'b1;
      end
   end

endmodule

// File: doc/booth_iter_mult.md
BOOTH_ITER_MULT -- requirements
Module: booth_iter_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; even, >= 4.
REQ-002 SHALL have derived constant N_PP = WIDTH/2 + 1: the partial-product (Booth digit) count.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of any in-flight or held operation.
REQ-006 SHALL have port in_valid, input, 1 bit: operand request.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-008 SHALL have port in_a, input, WIDTH bits: multiplicand.
REQ-009 SHALL have port in_b, input, WIDTH bits: multiplier.
REQ-010 SHALL have port in_a_signed, input, 1 bit: in_a is two's complement when 1, unsigned when 0.
REQ-011 SHALL have port in_b_signed, input, 1 bit: in_b is two's complement when 1, unsigned when 0.
REQ-012 SHALL have port out_valid, output, 1 bit: product available.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts product.
REQ-014 SHALL have port out_prod, output, 2*WIDTH bits: full product, two's complement.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-017 SHALL accept operands on the edge where in_valid&in_ready=1 and flush=0; it SHALL latch in_a, in_b and both sign bits, clear the accumulator and digit counter, and go IDLE->BUSY.
REQ-018 SHALL ignore operand changes after acceptance; in_valid while not IDLE has no effect.
REQ-019 SHALL extend the multiplier to WIDTH+2 bits (sign-extend if in_b_signed, else zero-extend) and recode it as radix-4 Booth digits d_i in {-2,-1,0,+1,+2}, i=0..N_PP-1, with implicit bit b[-1]=0.
REQ-020 SHALL extend the multiplicand to 2*WIDTH bits (sign or zero per in_a_signed); each partial product is d_i*A shifted left 2i, modulo 2^(2*WIDTH).
REQ-021 SHALL add exactly one partial product per BUSY cycle, in digit order i=0 first.
REQ-022 SHALL reduce the last digit (i=N_PP-1) to 0 or +1: it contributes +A iff in_b_signed=0 and in_b[WIDTH-1]=1, else 0. No negate or double is ever used for this digit.
REQ-023 SHALL go BUSY->DONE on the edge that adds digit N_PP-1, so out_valid asserts exactly N_PP cycles after the accepting edge (17 for WIDTH=32).
REQ-024 SHALL hold out_prod stable while out_valid=1 and out_ready=0, for unlimited cycles.
REQ-025 SHALL go DONE->IDLE on the edge where out_ready=1; in_ready=1 the next cycle. There is no same-cycle turnaround, so minimum op spacing is N_PP+2 cycles.
REQ-026 SHALL, on flush=1 at an edge in any state, go to IDLE, clear the counter, drop out_valid and discard the result; flush takes priority over acceptance and output handshake in the same cycle.
REQ-027 SHALL make the result equal (A_ext*B_ext) mod 2^(2*WIDTH) for all four signedness combinations.
REQ-028 SHALL drive out_prod to 0 whenever the state is not DONE.

Reset
REQ-029 SHALL force, while rst=1 (asynchronously, including mid-BUSY or DONE): state IDLE, in_ready=1, out_valid=0, out_prod=0, counter=0, accumulator=0.
REQ-030 SHALL resume normally on the first rising clk edge after rst deasserts.

Verification (WIDTH=32)
REQ-031 SHALL pass this case: a=0xFFFFFFFF, b=0xFFFFFFFF, both signed -> out_prod=0x0000000000000001, out_valid 17 cycles after acceptance.
REQ-032 SHALL pass this case: a=0xFFFFFFFF, b=0xFFFFFFFF, both unsigned -> out_prod=0xFFFFFFFE00000001 (last digit contributes +A).
REQ-033 SHALL pass these cases: a=0xFFFFFFFE signed, b=0x80000000 unsigned -> 0xFFFFFFFF00000000; a=b=0x80000000 signed -> 0x4000000000000000.
REQ-034 SHALL pass this case: out_ready held 0 for 10 cycles after out_valid -> out_prod and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL pass this case: flush=1 on the 5th BUSY cycle with in_valid=1 -> IDLE next cycle, no out_valid, no acceptance; next op 3*5 -> 15.
REQ-036 SHALL pass this case: rst pulsed mid-BUSY (between edges) -> outputs immediately at reset values; post-reset op 7*(-3) signed -> 0xFFFFFFFFFFFFFFEB.
